// File: rtl/viterbi_channel_inj_if.sv
// Symbol handshake between encoder, noisy channel and Viterbi decoder.
// Master drives encoded symbols in; slave returns the channel symbols.
interface viterbi_channel_inj_if;
  logic       enable_i;
  logic [1:0] d_in;
  logic [1:0] d_out;
  logic       valid_o;
  logic [1:0] inj_o;

  modport master (
    output enable_i,
    output d_in,
    input  d_out,
    input  valid_o,
    input  inj_o
  );

  modport slave (
    input  enable_i,
    input  d_in,
    output d_out,
    output valid_o,
    output inj_o
  );
endinterface

// File: rtl/viterbi_channel_inj.sv
// Noisy channel between convolutional encoder and Viterbi decoder.
// Injects clean/periodic/burst/random bit errors and counts them.
module viterbi_channel_inj #(
  parameter int          PERIOD    = 8,
  parameter int          BURST_LEN = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  viterbi_channel_inj_if.slave ch,
  input  logic [1:0]       mode,
  input  logic [7:0]       ber_thresh,
  output logic [CNT_W-1:0] word_ct,
  output logic [CNT_W-1:0] bad_bit_ct
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int RW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase;
  logic [RW-1:0] rem, rem_nxt;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nxt;
  logic [1:0]    mask;
  logic [1:0]    pop;
  logic [CNT_W:0] bad_sum;
  logic          phase0;
  logic          phase_last;

  assign phase0     = (phase == '0);
  assign phase_last = (phase == PW'(PERIOD - 1));

  // Galois form, taps 0xB400
  assign lfsr_nxt = {1'b0, lfsr[15:1]}
                  ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    mask      = 2'b00;
    state_nxt = state;
    rem_nxt   = rem;
    unique case (mode)
      2'b00: mask = 2'b00;
      2'b01: mask = phase0 ? 2'b10 : 2'b00;
      2'b10: begin
        unique case (state)
          IDLE: begin
            if (phase0) begin
              mask = 2'b10;
              if (BURST_LEN > 1) begin
                state_nxt = BURST;
                rem_nxt   = RW'(BURST_LEN - 1);
              end
            end
          end
          BURST: begin
            mask    = 2'b10;
            rem_nxt = rem - 1'b1;
            if (rem == RW'(1)) state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
      2'b11: begin
        mask[1] = (lfsr[7:0]  < ber_thresh);
        mask[0] = (lfsr[15:8] < ber_thresh);
      end
      default: mask = 2'b00;
    endcase
    // leaving burst mode aborts any burst in flight
    if (mode != 2'b10) state_nxt = IDLE;
  end

  assign pop     = {1'b0, mask[1]} + {1'b0, mask[0]};
  assign bad_sum = {1'b0, bad_bit_ct} + (CNT_W + 1)'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch.d_out   <= 2'b00;
      ch.valid_o <= 1'b0;
      ch.inj_o   <= 2'b00;
      word_ct    <= '0;
      bad_bit_ct <= '0;
      phase      <= '0;
      state      <= IDLE;
      rem        <= '0;
      lfsr       <= LFSR_SEED;
    end else if (ch.enable_i) begin
      ch.d_out   <= ch.d_in ^ mask;
      ch.valid_o <= 1'b1;
      ch.inj_o   <= mask;
      word_ct    <= word_ct + 1'b1;
      bad_bit_ct <= bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
      phase      <= phase_last ? '0 : phase + 1'b1;
      state      <= state_nxt;
      rem        <= rem_nxt;
      if (mode == 2'b11) lfsr <= lfsr_nxt;
    end else begin
      ch.valid_o <= 1'b0;
      ch.inj_o   <= 2'b00;
    end
  end

endmodule

// File: tb/tb_viterbi_channel_inj.sv
// Scoreboard bench for viterbi_channel_inj: a reference channel model
// queues expected outputs per driven cycle; a monitor pops and compares.
module tb_viterbi_channel_inj;

  localparam int PERIOD    = 8;
  localparam int BURST_LEN = 2;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic [1:0] inj;
    int         wc;
    int         bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  ber_thresh = 8'd0;
  logic [15:0] word_ct, bad_bit_ct;
  logic [3:0]  s_word_ct, s_bad_bit_ct;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q[$];

  int          m_phase, m_burst, m_wc, m_bc;
  logic [15:0] m_lfsr;
  logic [1:0]  m_dout;

  viterbi_channel_inj_if cif ();
  viterbi_channel_inj_if sif ();

  assign sif.enable_i = cif.enable_i;
  assign sif.d_in     = cif.d_in;

  viterbi_channel_inj dut (
    .clk        (clk),
    .rst        (rst),
    .ch         (cif.slave),
    .mode       (mode),
    .ber_thresh (ber_thresh),
    .word_ct    (word_ct),
    .bad_bit_ct (bad_bit_ct)
  );

  // narrow-counter copy exercises wrap and saturation quickly
  viterbi_channel_inj #(.CNT_W(4)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .ch         (sif.slave),
    .mode       (mode),
    .ber_thresh (ber_thresh),
    .word_ct    (s_word_ct),
    .bad_bit_ct (s_bad_bit_ct)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_burst = 0;
    m_wc    = 0;
    m_bc    = 0;
    m_lfsr  = 16'hACE1;
    m_dout  = 2'b00;
  endtask

  task automatic drive(input bit en, input logic [1:0] d,
                       input logic [1:0] md, input logic [7:0] thr);
    exp_t       e;
    logic [1:0] msk;
    @(negedge clk);
    cif.enable_i = en;
    cif.d_in     = d;
    mode         = md;
    ber_thresh   = thr;
    msk = 2'b00;
    if (en) begin
      case (md)
        2'b01: if (m_phase == 0) msk = 2'b10;
        2'b10: begin
          if (m_burst > 0) begin
            msk = 2'b10;
            m_burst--;
          end else if (m_phase == 0) begin
            msk = 2'b10;
            m_burst = BURST_LEN - 1;
          end
        end
        2'b11: begin
          msk[1] = (m_lfsr[7:0]  < thr);
          msk[0] = (m_lfsr[15:8] < thr);
          if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
          else           m_lfsr = m_lfsr >> 1;
        end
        default: msk = 2'b00;
      endcase
      if (md != 2'b10) m_burst = 0;
      m_phase = (m_phase + 1) % PERIOD;
      m_wc++;
      m_bc   = m_bc + int'(msk[1]) + int'(msk[0]);
      m_dout = d ^ msk;
    end
    e.v   = en;
    e.d   = m_dout;
    e.inj = msk;
    e.wc  = m_wc;
    e.bc  = m_bc;
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(cif.valid_o), 32'd0);
    check({tag, "_dout"},  32'(cif.d_out),   32'd0);
    check({tag, "_inj"},   32'(cif.inj_o),   32'd0);
    check({tag, "_wc"},    32'(word_ct),     32'd0);
    check({tag, "_bc"},    32'(bad_bit_ct),  32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    cif.enable_i = 1'b0;
    #2 rst = 1'b0;
    #1 check_zero(tag);
    q.delete();
    model_reset();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst && q.size() > 0) begin
      e = q.pop_front();
      check("valid", 32'(cif.valid_o), 32'(e.v));
      check("dout",  32'(cif.d_out),   32'(e.d));
      check("inj",   32'(cif.inj_o),   32'(e.inj));
      check("wc",    32'(word_ct),     32'(e.wc & 16'hFFFF));
      check("bc",    32'(bad_bit_ct),  32'((e.bc > 65535) ? 65535 : e.bc));
      check("s_wc",  32'(s_word_ct),   32'(e.wc & 15));
      check("s_bc",  32'(s_bad_bit_ct), 32'(sat15(e.bc)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cif.enable_i = 1'b0;
    cif.d_in     = 2'b00;
    model_reset();
    @(negedge clk);
    check_zero("rst0");
    #2 rst = 1'b1;

    do_reset("r1");
    for (int i = 0; i < 20; i++) drive(1'b1, 2'b10, 2'b00, 8'd0);
    settle();
    check("t1_wc", 32'(word_ct), 32'd20);
    check("t1_bc", 32'(bad_bit_ct), 32'd0);

    do_reset("r2");
    for (int i = 0; i < 24; i++) drive(1'b1, 2'b00, 2'b01, 8'd0);
    settle();
    check("t2_bc", 32'(bad_bit_ct), 32'd3);

    do_reset("r3");
    for (int i = 0; i < 16; i++) drive(1'b1, 2'b01, 2'b10, 8'd0);
    settle();
    check("t3_bc", 32'(bad_bit_ct), 32'd4);

    do_reset("r4a");
    for (int i = 0; i < 100; i++) drive(1'b1, 2'b00, 2'b11, 8'd0);
    settle();
    check("t4_bc0", 32'(bad_bit_ct), 32'd0);
    do_reset("r4b");
    for (int i = 0; i < 256; i++)
      drive(1'b1, 2'($urandom_range(0, 3)), 2'b11, 8'd128);
    settle();
    check("t4_wc", 32'(word_ct), 32'd256);

    do_reset("r5");
    for (int i = 0; i < 32; i++) drive((i % 2) == 0, 2'b00, 2'b01, 8'd0);
    drive(1'b0, 2'b00, 2'b01, 8'd0);
    settle();
    check("t5_wc", 32'(word_ct), 32'd16);
    check("t5_bc", 32'(bad_bit_ct), 32'd2);

    do_reset("r6a");
    drive(1'b1, 2'b01, 2'b10, 8'd0);
    settle();
    do_reset("r6b");
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 2'b10, 8'd0);
    settle();
    check("t6_bc", 32'(bad_bit_ct), 32'd2);

    do_reset("r7");
    drive(1'b1, 2'b00, 2'b10, 8'd0);
    drive(1'b1, 2'b00, 2'b01, 8'd0);
    drive(1'b1, 2'b00, 2'b10, 8'd0);
    settle();
    check("abort_bc", 32'(bad_bit_ct), 32'd1);

    do_reset("r8a");
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b11, 2'b11, 8'd128);
    do_reset("r8b");
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b11, 2'b11, 8'd128);

    do_reset("r9");
    for (int i = 0; i < 20; i++) drive(1'b1, 2'b00, 2'b11, 8'd255);
    drive(1'b0, 2'b00, 2'b11, 8'd255);
    settle();
    check("sat_bc", 32'(s_bad_bit_ct), 32'(sat15(m_bc)));

    repeat (2) @(negedge clk);
    check("q_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
